mem_port_arbiter: RTL and testbench

//  Shares one line-wide main-memory port between two dm_cache_fsm-style requesters (req 0 = I-cache, req 1 = D-cache).

---
 rtl/mem_port_arbiter_if.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 109 ++++++++++
 tb/tb_mem_port_arbiter.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundled request/response buses between the two cache FSMs, the arbiter and main memory.
// slave = arbiter view; master = view of the requesters and memory driving it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 128
);
  logic [ADDR_W-1:0] r0_req_addr;
  logic [LINE_W-1:0] r0_req_data;
  logic              r0_req_rw;
  logic              r0_req_valid;
  logic [LINE_W-1:0] r0_mem_data;
  logic              r0_mem_ready;

  logic [ADDR_W-1:0] r1_req_addr;
  logic [LINE_W-1:0] r1_req_data;
  logic              r1_req_rw;
  logic              r1_req_valid;
  logic [LINE_W-1:0] r1_mem_data;
  logic              r1_mem_ready;

  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_data;
  logic              mem_req_rw;
  logic              mem_req_valid;
  logic [LINE_W-1:0] mem_data;
  logic              mem_ready;

  modport slave (
    input  r0_req_addr, r0_req_data, r0_req_rw, r0_req_valid,
    input  r1_req_addr, r1_req_data, r1_req_rw, r1_req_valid,
    input  mem_data, mem_ready,
    output r0_mem_data, r0_mem_ready, r1_mem_data, r1_mem_ready,
    output mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid
  );

  modport master (
    output r0_req_addr, r0_req_data, r0_req_rw, r0_req_valid,
    output r1_req_addr, r1_req_data, r1_req_rw, r1_req_valid,
    output mem_data, mem_ready,
    input  r0_mem_data, r0_mem_ready, r1_mem_data, r1_mem_ready,
    input  mem_req_addr, mem_req_data, mem_req_rw, mem_req_valid
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between I-cache (req 0) and D-cache (req 1).
// Define MEM_ARB_STATS_EN to build saturating grant/wait counters; otherwise they read 0.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 128,
    parameter int unsigned STAT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus,
    output logic [STAT_W-1:0] grant_cnt0,
    output logic [STAT_W-1:0] grant_cnt1,
    output logic [STAT_W-1:0] wait_cnt0,
    output logic [STAT_W-1:0] wait_cnt1
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state;
    logic              owner;
    logic              last;
    logic              busy;
    logic              own_valid;
    logic              next_owner;
    logic              grant;
    logic              done;
    logic              abort;
    logic [ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0] sel_data;
    logic              sel_rw;
    logic              sel_valid;

    always_comb begin
        busy       = (state == BUSY);
        own_valid  = owner ? bus.r1_req_valid : bus.r0_req_valid;
        // Contention goes to whoever was not served last; a lone requester always wins.
        next_owner = (bus.r0_req_valid && bus.r1_req_valid) ? ~last : bus.r1_req_valid;
        grant      = !busy && (bus.r0_req_valid || bus.r1_req_valid);
        done       = busy && bus.mem_ready;
        abort      = busy && !bus.mem_ready && !own_valid;
        sel_addr   = '0;
        sel_data   = '0;
        sel_rw     = 1'b0;
        sel_valid  = 1'b0;
        if (busy) begin
            sel_addr  = owner ? bus.r1_req_addr  : bus.r0_req_addr;
            sel_data  = owner ? bus.r1_req_data  : bus.r0_req_data;
            sel_rw    = owner ? bus.r1_req_rw    : bus.r0_req_rw;
            sel_valid = own_valid;
        end
    end

    assign bus.mem_req_addr  = sel_addr;
    assign bus.mem_req_data  = sel_data;
    assign bus.mem_req_rw    = sel_rw;
    assign bus.mem_req_valid = sel_valid;
    assign bus.r0_mem_ready  = done && !owner;
    assign bus.r1_mem_ready  = done && owner;
    assign bus.r0_mem_data   = bus.mem_data;
    assign bus.r1_mem_data   = bus.mem_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else if (grant) begin
            state <= BUSY;
            owner <= next_owner;
        end else if (done) begin
            state <= IDLE;
            last  <= owner;
        end else if (abort) begin
            state <= IDLE;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] g0_q, g1_q, w0_q, w1_q;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_q <= '0;
            g1_q <= '0;
            w0_q <= '0;
            w1_q <= '0;
        end else begin
            if (grant && !next_owner) g0_q <= sat_inc(g0_q);
            if (grant && next_owner)  g1_q <= sat_inc(g1_q);
            if (bus.r0_req_valid && !(busy && !owner)) w0_q <= sat_inc(w0_q);
            if (bus.r1_req_valid && !(busy && owner))  w1_q <= sat_inc(w1_q);
        end
    end

    assign grant_cnt0 = g0_q;
    assign grant_cnt1 = g1_q;
    assign wait_cnt0  = w0_q;
    assign wait_cnt1  = w1_q;
`else
    assign grant_cnt0 = '0;
    assign grant_cnt1 = '0;
    assign wait_cnt0  = '0;
    assign wait_cnt1  = '0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; counter expectations follow MEM_ARB_STATS_EN.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned STAT_W = 4;
`ifdef MEM_ARB_STATS_EN
  localparam int unsigned STATS = 1;
`else
  localparam int unsigned STATS = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [STAT_W-1:0] grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1;
  int tests = 0;
  int fails = 0;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .wait_cnt0(wait_cnt0), .wait_cnt1(wait_cnt1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_req_addr = '0; bus.r0_req_data = '0; bus.r0_req_rw = 1'b0; bus.r0_req_valid = 1'b0;
    bus.r1_req_addr = '0; bus.r1_req_data = '0; bus.r1_req_rw = 1'b0; bus.r1_req_valid = 1'b0;
    bus.mem_data = '0; bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", bus.mem_req_valid); end
    tests++; if (bus.mem_req_addr !== '0) begin fails++; $display("FAIL rst_addr got %h exp 0", bus.mem_req_addr); end
    tests++; if ({bus.r0_mem_ready, bus.r1_mem_ready} !== 2'b00) begin fails++; $display("FAIL rst_ready got %b exp 00", {bus.r0_mem_ready, bus.r1_mem_ready}); end
    tests++; if ({grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1} !== '0) begin fails++; $display("FAIL rst_cnt got %h exp 0", {grant_cnt0, grant_cnt1, wait_cnt0, wait_cnt1}); end
    rst = 1'b0;
    bus.r0_req_addr = 32'h0; bus.r0_req_rw = 1'b0; bus.r0_req_valid = 1'b1;
    #1;
    tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL arb_cycle_valid got %b exp 0", bus.mem_req_valid); end
    step();
    tests++; if (bus.mem_req_valid !== 1'b1) begin fails++; $display("FAIL first_valid got %b exp 1", bus.mem_req_valid); end
    tests++; if ({bus.mem_req_addr, bus.mem_req_rw} !== {32'h0, 1'b0}) begin fails++; $display("FAIL first_addr_rw got %h/%b exp 0/0", bus.mem_req_addr, bus.mem_req_rw); end
  endtask

  // Continues the read left in flight by test_reset.
  task automatic test_single_read();
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.r0_mem_ready !== 1'b0) begin fails++; $display("FAIL read_early_ready cyc %0d got %b exp 0", i, bus.r0_mem_ready); end
      step();
    end
    bus.mem_data = {4{32'h1111_1111}};
    bus.mem_ready = 1'b1;
    #1;
    tests++; if (bus.r0_mem_ready !== 1'b1) begin fails++; $display("FAIL read_ready got %b exp 1", bus.r0_mem_ready); end
    tests++; if (bus.r0_mem_data !== {4{32'h1111_1111}}) begin fails++; $display("FAIL read_data got %h exp 1111..", bus.r0_mem_data); end
    tests++; if (bus.r1_mem_ready !== 1'b0) begin fails++; $display("FAIL read_r1_ready got %b exp 0", bus.r1_mem_ready); end
    step();
    bus.mem_ready = 1'b0;
    bus.r0_req_valid = 1'b0;
    #1;
    tests++; if ({bus.r0_mem_ready, bus.mem_req_valid} !== 2'b00) begin fails++; $display("FAIL read_after got %b exp 00", {bus.r0_mem_ready, bus.mem_req_valid}); end
  endtask

  task automatic test_contention();
    do_reset();
    bus.r0_req_addr = 32'h40; bus.r0_req_rw = 1'b0; bus.r0_req_valid = 1'b1;
    bus.r1_req_addr = 32'h80; bus.r1_req_data = {16{8'hA5}}; bus.r1_req_rw = 1'b1; bus.r1_req_valid = 1'b1;
    step();
    tests++; if (bus.mem_req_addr !== 32'h40) begin fails++; $display("FAIL cont_first got %h exp 40", bus.mem_req_addr); end
    step();
    bus.mem_ready = 1'b1;
    #1;
    tests++; if ({bus.r0_mem_ready, bus.r1_mem_ready} !== 2'b10) begin fails++; $display("FAIL cont_r0_done got %b exp 10", {bus.r0_mem_ready, bus.r1_mem_ready}); end
    step();
    bus.mem_ready = 1'b0;
    bus.r0_req_valid = 1'b0;
    #1;
    tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL cont_gap got %b exp 0", bus.mem_req_valid); end
    step();
    tests++; if ({bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr} !== {2'b11, 32'h80}) begin fails++; $display("FAIL cont_r1_req got %b%b/%h exp 11/80", bus.mem_req_valid, bus.mem_req_rw, bus.mem_req_addr); end
    tests++; if (bus.mem_req_data !== {16{8'hA5}}) begin fails++; $display("FAIL cont_r1_data got %h exp a5..", bus.mem_req_data); end
    bus.mem_ready = 1'b1;
    #1;
    tests++; if ({bus.r0_mem_ready, bus.r1_mem_ready} !== 2'b01) begin fails++; $display("FAIL cont_r1_done got %b exp 01", {bus.r0_mem_ready, bus.r1_mem_ready}); end
    step();
    bus.mem_ready = 1'b0;
    bus.r1_req_valid = 1'b0;
  endtask

  task automatic test_fairness();
    logic [31:0] exp_addr;
    do_reset();
    bus.r0_req_addr = 32'h100; bus.r0_req_valid = 1'b1;
    bus.r1_req_addr = 32'h200; bus.r1_req_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h100 : 32'h200;
      step();
      tests++; if (bus.mem_req_addr !== exp_addr) begin fails++; $display("FAIL fair_order txn %0d got %h exp %h", k, bus.mem_req_addr, exp_addr); end
      step();
      bus.mem_ready = 1'b1;
      #1;
      tests++; if (bus.r1_mem_ready !== (k % 2 == 1)) begin fails++; $display("FAIL fair_ready txn %0d got r1=%b", k, bus.r1_mem_ready); end
      step();
      bus.mem_ready = 1'b0;
      #1;
      tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL fair_gap txn %0d got %b exp 0", k, bus.mem_req_valid); end
    end
    tests++; if ({grant_cnt0, grant_cnt1} !== {STAT_W'(3 * STATS), STAT_W'(3 * STATS)}) begin fails++; $display("FAIL fair_grants got %0d/%0d exp %0d", grant_cnt0, grant_cnt1, 3 * STATS); end
    tests++; if ({wait_cnt0, wait_cnt1} !== {STAT_W'(12 * STATS), STAT_W'(12 * STATS)}) begin fails++; $display("FAIL fair_waits got %0d/%0d exp %0d", wait_cnt0, wait_cnt1, 12 * STATS); end
    // r0 holds the port while r1 keeps waiting: r1's counter must stick at all-ones.
    for (int i = 0; i < 6; i++) step();
    tests++; if ({wait_cnt0, wait_cnt1} !== {STAT_W'(13 * STATS), STAT_W'(15 * STATS)}) begin fails++; $display("FAIL sat_waits got %0d/%0d exp %0d/%0d", wait_cnt0, wait_cnt1, 13 * STATS, 15 * STATS); end
    tests++; if (grant_cnt0 !== STAT_W'(4 * STATS)) begin fails++; $display("FAIL sat_grant0 got %0d exp %0d", grant_cnt0, 4 * STATS); end
    clear_inputs();
  endtask

  task automatic test_abort_spurious();
    do_reset();
    bus.r0_req_addr = 32'h40;
    bus.r1_req_addr = 32'h80; bus.r1_req_rw = 1'b1; bus.r1_req_valid = 1'b1;
    step();
    tests++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 32'h80}) begin fails++; $display("FAIL abort_grant got %b/%h exp 1/80", bus.mem_req_valid, bus.mem_req_addr); end
    step();
    bus.r1_req_valid = 1'b0;
    #1;
    tests++; if ({bus.mem_req_valid, bus.r1_mem_ready} !== 2'b00) begin fails++; $display("FAIL abort_drop got %b exp 00", {bus.mem_req_valid, bus.r1_mem_ready}); end
    step();
    bus.mem_ready = 1'b1;
    #1;
    tests++; if ({bus.r0_mem_ready, bus.r1_mem_ready, bus.mem_req_valid} !== 3'b000) begin fails++; $display("FAIL spurious got %b exp 000", {bus.r0_mem_ready, bus.r1_mem_ready, bus.mem_req_valid}); end
    step();
    bus.mem_ready = 1'b0;
    bus.r0_req_valid = 1'b1; bus.r1_req_valid = 1'b1;
    step();
    tests++; if (bus.mem_req_addr !== 32'h40) begin fails++; $display("FAIL abort_last got %h exp 40", bus.mem_req_addr); end
    bus.mem_ready = 1'b1; bus.r0_req_valid = 1'b0;
    #1;
    tests++; if (bus.r0_mem_ready !== 1'b1) begin fails++; $display("FAIL coincident_ready got %b exp 1", bus.r0_mem_ready); end
    step();
    bus.mem_ready = 1'b0; bus.r0_req_valid = 1'b1;
    step();
    tests++; if (bus.mem_req_addr !== 32'h80) begin fails++; $display("FAIL coincident_last got %h exp 80", bus.mem_req_addr); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    bus.r0_req_addr = 32'h300; bus.r0_req_valid = 1'b1;
    step();
    tests++; if (bus.mem_req_valid !== 1'b1) begin fails++; $display("FAIL midrst_busy got %b exp 1", bus.mem_req_valid); end
    rst = 1'b1;
    #1;
    tests++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b0, 32'h0}) begin fails++; $display("FAIL midrst_async got %b/%h exp 0/0", bus.mem_req_valid, bus.mem_req_addr); end
    step();
    bus.r1_req_addr = 32'h400; bus.r1_req_valid = 1'b1;
    rst = 1'b0;
    #1;
    tests++; if (bus.mem_req_valid !== 1'b0) begin fails++; $display("FAIL midrst_idle got %b exp 0", bus.mem_req_valid); end
    step();
    tests++; if ({bus.mem_req_valid, bus.mem_req_addr} !== {1'b1, 32'h300}) begin fails++; $display("FAIL midrst_regrant got %b/%h exp 1/300", bus.mem_req_valid, bus.mem_req_addr); end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_fairness();
    test_abort_spurious();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
